uart_load_sequencer: RTL and testbench
======================================

# uart_load_sequencer

Controller that sequences UART reprogramming of the instruction and data memories. It sits beside the hazard unit and drives the fetch stage's `uart_disable`, `hazard_control` and `pc_reset` inputs. It freezes fetch, lets the pipeline drain, and hands the memory write ports to the UART unit. It then counts the words written, ends the session on UART completion or on a watchdog timeout, and restarts execution at PC 0.

## Interface
- `DRAIN_CYCLES`, 4: NO_OP cycles issued before the UART is granted; must be ≥ pipeline depth − 1.
- `LOAD_TIMEOUT`, 2^24: cycles without `uart_write_enable` in LOAD before the session is aborted.
- `CNT_WIDTH`, 16: width of each word counter.
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart_start` in 1: level request from the board button (already debounced); internally rising-edge detected.
- `uart_done` in 1: UART unit finished (upg_done_o).
- `uart_write_enable` in 1: UART write strobe (upg_wen_o).
- `uart_addr` in `ROM_DEPTH+1`: UART word address; MSB=0 → instruction memory, MSB=1 → data memory.
- `uart_disable` out 1: 1 = memories on the pipeline side, 0 = UART owns the write ports.
- `uart_rst_n` out 1: active-low reset to the UART unit; low except in LOAD.
- `hazard_control` out `HAZD_CTL_WIDTH`: next-state command to the fetch stage.
- `pc_reset` out 1: forces the fetch stage's `pc_next` to 0.
- `loading` out 1: high in DRAIN, LOAD and FINISH.
- `load_error` out 1: sticky; set on timeout and cleared at the next session start.
- `imem_words`, `dmem_words` out `CNT_WIDTH`: words written in the current or last session; saturating.

## Operation
- States:
  - IDLE: `uart_disable`=1, `hazard_control`=`HAZD_CTL_NORMAL`.
  - DRAIN: NO_OP, `uart_disable`=1, down-counter from `DRAIN_CYCLES`−1.
  - LOAD: NO_OP, `uart_disable`=0, `uart_rst_n`=1.
  - FINISH: NO_OP, `pc_reset`=1, `uart_disable`=1, lasts exactly one cycle.
- IDLE → DRAIN on a rising edge of `uart_start`. The same edge clears both counters, clears `load_error` and loads the drain counter.
- DRAIN → LOAD when the drain counter reaches 0, i.e. after exactly `DRAIN_CYCLES` DRAIN cycles.
- LOAD → FINISH on `uart_done`, or when the idle-timer hits `LOAD_TIMEOUT`−1; the timeout also sets `load_error`.
- The idle-timer clears on every `uart_write_enable` and on entry to LOAD.
- FINISH → IDLE unconditionally.
- In LOAD, each cycle with `uart_write_enable`=1 increments `imem_words` if `uart_addr[ROM_DEPTH]`=0, otherwise `dmem_words`. Counters hold at all-ones, with no wrap.
- `uart_start` edges outside IDLE are ignored. The edge detector's history register still updates, so a held button does not retrigger in IDLE.
- `uart_done` together with `uart_write_enable` in the same cycle: the write is counted and the FSM goes to FINISH.
- `uart_done` and timeout in the same cycle: `uart_done` wins and `load_error` stays 0.
- `uart_done` outside LOAD is ignored.
- `hazard_control` never takes the value `HAZD_CTL_RETRY`.

## Timing
- All outputs are registered, derived from the state register and counters with no input-to-output combinational path.
- Reset values:
  - state IDLE
  - `uart_disable`=1, `uart_rst_n`=0
  - `hazard_control`=`HAZD_CTL_NORMAL`
  - `pc_reset`=0, `loading`=0, `load_error`=0
  - counters 0
  - edge-detect history 0
- Latency from `uart_start` rising (sampled at edge N) to `hazard_control`=NO_OP is cycle N+1. `uart_disable` falls at N+1+`DRAIN_CYCLES`.
- `pc_reset` is high for one cycle, concurrently with NO_OP, so the fetch stage loads PC=0 during FINISH. Fetch resumes (NORMAL) the following cycle.
- An asynchronous reset mid-session returns to IDLE immediately: `uart_disable`=1 and the UART is held in reset. Partially written memory contents are not rolled back.

## Structure
- Add to definitions.v: `UART_SEQ_STATE_WIDTH` (2) and the state encodings `UART_SEQ_IDLE`/`DRAIN`/`LOAD`/`FINISH`.
- Reuse `HAZD_CTL_*`, `ROM_DEPTH` and `ISA_WIDTH` from definitions.v.
- One sub-module, `edge_detector` (rising-edge, registered), for `uart_start`. The counters and FSM stay in this module.

## Test plan
- Reset, then `uart_start` pulse at cycle 10 with `DRAIN_CYCLES`=4 → NO_OP from cycle 11, `uart_disable`=0 from cycle 15, `uart_rst_n`=1 from cycle 15.
- In LOAD, 3 writes at addr 0x0000–0x0002 and 2 at addr with MSB set, then `uart_done` → `imem_words`=3, `dmem_words`=2, one-cycle `pc_reset` with NO_OP, then NORMAL, `load_error`=0.
- `LOAD_TIMEOUT`=16 and no writes in LOAD → FINISH after 16 LOAD cycles, `load_error`=1. A new `uart_start` clears it.
- `uart_done` together with `uart_write_enable` (MSB=0) → `imem_words` incremented and FINISH next cycle. `uart_done` on the timeout cycle → `load_error`=0.
- `uart_start` held high across the whole session and returned to IDLE → no second session. `uart_start` pulses during DRAIN and LOAD → ignored.
- `rst_n` low during LOAD with writes pending → immediately `uart_disable`=1, `uart_rst_n`=0, state IDLE, counters 0.
- `CNT_WIDTH`=4 with 20 instruction writes → `imem_words` saturates at 15.

Source files
------------

// File: rtl/uart_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_load_sequencer_pkg
// Description : Shared definitions for the UART load sequencer. Holds the
//               processor-wide constants (hazard command encodings, ROM depth,
//               ISA width), the sequencer state encodings and the registered
//               output bundle type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_load_sequencer_pkg;

    // ------------------------------------------------------------------------
    // Processor-wide definitions
    // ------------------------------------------------------------------------
    localparam int ISA_WIDTH      = 32;
    // Word-address width of each memory. The UART address carries one extra
    // MSB that selects instruction (0) or data (1) memory.
    localparam int ROM_DEPTH      = 14;

    // Next-state command to the fetch stage.
    localparam int HAZD_CTL_WIDTH = 2;
    localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_NORMAL = 2'b00;
    localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_RETRY  = 2'b01;
    localparam logic [HAZD_CTL_WIDTH-1:0] HAZD_CTL_NO_OP  = 2'b10;

    // ------------------------------------------------------------------------
    // Sequencer state encodings
    // ------------------------------------------------------------------------
    localparam int UART_SEQ_STATE_WIDTH = 2;
    localparam logic [UART_SEQ_STATE_WIDTH-1:0] UART_SEQ_IDLE   = 2'd0;
    localparam logic [UART_SEQ_STATE_WIDTH-1:0] UART_SEQ_DRAIN  = 2'd1;
    localparam logic [UART_SEQ_STATE_WIDTH-1:0] UART_SEQ_LOAD   = 2'd2;
    localparam logic [UART_SEQ_STATE_WIDTH-1:0] UART_SEQ_FINISH = 2'd3;

    // ------------------------------------------------------------------------
    // Registered control outputs, grouped so they can be computed from the
    // next state in one place and registered together.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic                      uart_disable;
        logic                      uart_rst_n;
        logic [HAZD_CTL_WIDTH-1:0] hazard_control;
        logic                      pc_reset;
        logic                      loading;
    } seq_out_t;

    // Values the control outputs take while in IDLE and during reset.
    localparam seq_out_t SEQ_OUT_IDLE = '{
        uart_disable   : 1'b1,
        uart_rst_n     : 1'b0,
        hazard_control : HAZD_CTL_NORMAL,
        pc_reset       : 1'b0,
        loading        : 1'b0
    };

endpackage : uart_load_sequencer_pkg
`default_nettype wire

// File: rtl/uart_load_sequencer_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector
// Description : Rising-edge detector with a registered history bit. The
//               history register updates every cycle regardless of how the
//               pulse is consumed, so a level held high yields exactly one
//               pulse.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset (history cleared to 0)
//               i_sig  - level input, already synchronous to clk
//               o_rise - high for the cycle in which i_sig is 1 and was 0
//                        on the previous cycle
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    // The pulse is combinational from i_sig so the consumer can act on the
    // same edge that samples the rising level.
    assign o_rise = i_sig & ~r_prev;

endmodule : edge_detector
`default_nettype wire

// File: rtl/uart_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_load_sequencer
// Description : Sequences UART reprogramming of the instruction and data
//               memories. On a start request it freezes fetch (NO_OP), drains
//               the pipeline, hands the memory write ports to the UART unit,
//               counts the words written, closes the session on UART
//               completion or watchdog timeout and restarts fetch at PC 0.
// Ports       : clk               - system clock
//               rst_n             - asynchronous active-low reset
//               uart_start        - debounced start button level
//               uart_done         - UART unit finished
//               uart_write_enable - UART write strobe
//               uart_addr         - UART word address, MSB selects dmem
//               uart_disable      - 1: pipeline owns memories, 0: UART owns
//               uart_rst_n        - active-low UART reset, released in LOAD
//               hazard_control    - next-state command to fetch
//               pc_reset          - force fetch pc_next to 0
//               loading           - session in progress (DRAIN/LOAD/FINISH)
//               load_error        - sticky watchdog-timeout flag
//               imem_words        - saturating instruction word count
//               dmem_words        - saturating data word count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_load_sequencer
    import uart_load_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,        // >= 1, >= pipeline depth - 1
    parameter int LOAD_TIMEOUT = 2 ** 24,  // >= 2
    parameter int CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      uart_start,
    input  logic                      uart_done,
    input  logic                      uart_write_enable,
    input  logic [ROM_DEPTH:0]        uart_addr,
    output logic                      uart_disable,
    output logic                      uart_rst_n,
    output logic [HAZD_CTL_WIDTH-1:0] hazard_control,
    output logic                      pc_reset,
    output logic                      loading,
    output logic                      load_error,
    output logic [CNT_WIDTH-1:0]      imem_words,
    output logic [CNT_WIDTH-1:0]      dmem_words
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_drn_w = $clog2(DRAIN_CYCLES + 1);
    localparam int c_tmr_w = $clog2(LOAD_TIMEOUT);

    localparam logic [c_drn_w-1:0]   c_drn_init = c_drn_w'(DRAIN_CYCLES - 1);
    localparam logic [c_drn_w-1:0]   c_drn_zero = '0;
    localparam logic [c_tmr_w-1:0]   c_tmr_max  = c_tmr_w'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [UART_SEQ_STATE_WIDTH-1:0] r_state;
    logic [UART_SEQ_STATE_WIDTH-1:0] w_state_nxt;

    seq_out_t                        r_out;
    seq_out_t                        w_out_nxt;

    logic [c_drn_w-1:0]              r_drn_cnt;
    logic [c_tmr_w-1:0]              r_tmr;
    logic                            r_load_error;
    logic [CNT_WIDTH-1:0]            r_imem_words;
    logic [CNT_WIDTH-1:0]            r_dmem_words;

    logic                            w_start_rise;
    logic                            w_session_start;
    logic                            w_in_load;
    logic                            w_timeout;
    logic                            w_sel_dmem;
    logic                            w_unused_addr;

    // ------------------------------------------------------------------------
    // Start request edge detection
    // ------------------------------------------------------------------------
    edge_detector u_start_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (uart_start),
        .o_rise (w_start_rise)
    );

    // Edges seen outside IDLE are dropped here; the detector history still
    // follows the button so a held level cannot retrigger later.
    assign w_session_start = (r_state == UART_SEQ_IDLE) && w_start_rise;
    assign w_in_load       = (r_state == UART_SEQ_LOAD);

    // A cycle carrying a write is not an idle cycle, so it cannot time out.
    assign w_timeout       = w_in_load && (r_tmr == c_tmr_max) && !uart_write_enable;

    assign w_sel_dmem      = uart_addr[ROM_DEPTH];
    // Only the memory-select bit is of interest; the word address itself
    // goes straight from the UART unit to the memories.
    assign w_unused_addr   = ^uart_addr[ROM_DEPTH-1:0];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UART_SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UART_SEQ_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = UART_SEQ_DRAIN;
                end
            end
            UART_SEQ_DRAIN: begin
                if (r_drn_cnt == c_drn_zero) begin
                    w_state_nxt = UART_SEQ_LOAD;
                end
            end
            UART_SEQ_LOAD: begin
                // uart_done takes priority; both close the session.
                if (uart_done || w_timeout) begin
                    w_state_nxt = UART_SEQ_FINISH;
                end
            end
            UART_SEQ_FINISH: begin
                w_state_nxt = UART_SEQ_IDLE;
            end
            default: begin
                w_state_nxt = UART_SEQ_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state register and have no combinational path
    // from any input.
    // ------------------------------------------------------------------------
    always_comb begin
        w_out_nxt = SEQ_OUT_IDLE;
        case (w_state_nxt)
            UART_SEQ_DRAIN: begin
                w_out_nxt.hazard_control = HAZD_CTL_NO_OP;
                w_out_nxt.loading        = 1'b1;
            end
            UART_SEQ_LOAD: begin
                w_out_nxt.hazard_control = HAZD_CTL_NO_OP;
                w_out_nxt.uart_disable   = 1'b0;
                w_out_nxt.uart_rst_n     = 1'b1;
                w_out_nxt.loading        = 1'b1;
            end
            UART_SEQ_FINISH: begin
                // NO_OP together with pc_reset makes fetch load PC 0 now and
                // resume normally on the following cycle.
                w_out_nxt.hazard_control = HAZD_CTL_NO_OP;
                w_out_nxt.pc_reset       = 1'b1;
                w_out_nxt.loading        = 1'b1;
            end
            default: begin
                w_out_nxt = SEQ_OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= SEQ_OUT_IDLE;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Drain down-counter: loaded on session start, counts DRAIN_CYCLES-1..0
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drn_cnt <= '0;
        end else if (w_session_start) begin
            r_drn_cnt <= c_drn_init;
        end else if ((r_state == UART_SEQ_DRAIN) && (r_drn_cnt != c_drn_zero)) begin
            r_drn_cnt <= r_drn_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Idle watchdog: held at 0 outside LOAD, so LOAD is always entered with a
    // cleared timer. Each write restarts it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (!w_in_load || uart_write_enable) begin
            r_tmr <= '0;
        end else if (r_tmr != c_tmr_max) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky timeout flag: cleared only by the next session start
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_error <= 1'b0;
        end else if (w_session_start) begin
            r_load_error <= 1'b0;
        end else if (w_timeout && !uart_done) begin
            r_load_error <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Word counters: saturate at all-ones, cleared on session start
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_words <= '0;
            r_dmem_words <= '0;
        end else if (w_session_start) begin
            r_imem_words <= '0;
            r_dmem_words <= '0;
        end else if (w_in_load && uart_write_enable) begin
            if (w_sel_dmem) begin
                if (r_dmem_words != c_cnt_max) begin
                    r_dmem_words <= r_dmem_words + 1'b1;
                end
            end else begin
                if (r_imem_words != c_cnt_max) begin
                    r_imem_words <= r_imem_words + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign uart_disable   = r_out.uart_disable;
    assign uart_rst_n     = r_out.uart_rst_n;
    assign hazard_control = r_out.hazard_control;
    assign pc_reset       = r_out.pc_reset;
    assign loading        = r_out.loading;
    assign load_error     = r_load_error;
    assign imem_words     = r_imem_words;
    assign dmem_words     = r_dmem_words;

endmodule : uart_load_sequencer
`default_nettype wire

// File: tb/tb_uart_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_load_sequencer
// Description : Directed self-checking bench for uart_load_sequencer with
//               DRAIN_CYCLES=4, LOAD_TIMEOUT=16, CNT_WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_load_sequencer;
    import uart_load_sequencer_pkg::*;

    localparam int c_drain   = 4;
    localparam int c_timeout = 16;
    localparam int c_cw      = 4;

    logic                      clk;
    logic                      rst_n;
    logic                      uart_start;
    logic                      uart_done;
    logic                      uart_write_enable;
    logic [ROM_DEPTH:0]        uart_addr;
    logic                      uart_disable;
    logic                      uart_rst_n;
    logic [HAZD_CTL_WIDTH-1:0] hazard_control;
    logic                      pc_reset;
    logic                      loading;
    logic                      load_error;
    logic [c_cw-1:0]           imem_words;
    logic [c_cw-1:0]           dmem_words;

    int n_chk;
    int n_fail;

    uart_load_sequencer #(
        .DRAIN_CYCLES (c_drain),
        .LOAD_TIMEOUT (c_timeout),
        .CNT_WIDTH    (c_cw)
    ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_start        (uart_start),
        .uart_done         (uart_done),
        .uart_write_enable (uart_write_enable),
        .uart_addr         (uart_addr),
        .uart_disable      (uart_disable),
        .uart_rst_n        (uart_rst_n),
        .hazard_control    (hazard_control),
        .pc_reset          (pc_reset),
        .loading           (loading),
        .load_error        (load_error),
        .imem_words        (imem_words),
        .dmem_words        (dmem_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute bound on simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start in IDLE and advance to the first LOAD cycle.
    task automatic enter_load();
        uart_start = 1'b1;
        step();
        uart_start = 1'b0;
        repeat (c_drain) step();
    endtask

    initial begin
        n_chk             = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        uart_start        = 1'b0;
        uart_done         = 1'b0;
        uart_write_enable = 1'b0;
        uart_addr         = '0;

        // ---------------- reset state ----------------
        repeat (2) step();
        chk("rst_uart_disable", 32'(uart_disable), 32'd1);
        chk("rst_uart_rst_n", 32'(uart_rst_n), 32'd0);
        chk("rst_hazard", 32'(hazard_control), 32'(HAZD_CTL_NORMAL));
        chk("rst_pc_reset", 32'(pc_reset), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_imem", 32'(imem_words), 32'd0);
        chk("rst_dmem", 32'(dmem_words), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_hazard", 32'(hazard_control), 32'(HAZD_CTL_NORMAL));

        // ---------------- start latency and drain length ----------------
        uart_start = 1'b1;
        step();
        uart_start = 1'b0;
        chk("drain1_hazard", 32'(hazard_control), 32'(HAZD_CTL_NO_OP));
        chk("drain1_disable", 32'(uart_disable), 32'd1);
        chk("drain1_loading", 32'(loading), 32'd1);
        chk("drain1_uart_rst_n", 32'(uart_rst_n), 32'd0);
        repeat (c_drain - 1) step();
        chk("drain4_disable", 32'(uart_disable), 32'd1);
        step();
        chk("load1_disable", 32'(uart_disable), 32'd0);
        chk("load1_uart_rst_n", 32'(uart_rst_n), 32'd1);
        chk("load1_hazard", 32'(hazard_control), 32'(HAZD_CTL_NO_OP));

        // ---------------- 3 imem + 2 dmem writes then done ----------------
        uart_write_enable = 1'b1;
        uart_addr = 15'h0000; step();
        chk("w1_imem", 32'(imem_words), 32'd1);
        uart_addr = 15'h0001; step();
        uart_addr = 15'h0002; step();
        uart_addr = 15'h4000; step();
        uart_addr = 15'h4001; step();
        uart_write_enable = 1'b0;
        chk("w5_imem", 32'(imem_words), 32'd3);
        chk("w5_dmem", 32'(dmem_words), 32'd2);
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
        chk("fin_pc_reset", 32'(pc_reset), 32'd1);
        chk("fin_hazard", 32'(hazard_control), 32'(HAZD_CTL_NO_OP));
        chk("fin_disable", 32'(uart_disable), 32'd1);
        chk("fin_uart_rst_n", 32'(uart_rst_n), 32'd0);
        step();
        chk("post_pc_reset", 32'(pc_reset), 32'd0);
        chk("post_hazard", 32'(hazard_control), 32'(HAZD_CTL_NORMAL));
        chk("post_loading", 32'(loading), 32'd0);
        chk("post_load_error", 32'(load_error), 32'd0);
        chk("post_imem_hold", 32'(imem_words), 32'd3);

        // ---------------- uart_done outside LOAD ignored ----------------
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
        chk("idle_done_loading", 32'(loading), 32'd0);
        chk("idle_done_pc_reset", 32'(pc_reset), 32'd0);

        // ---------------- watchdog timeout ----------------
        enter_load();
        chk("to_clear_imem", 32'(imem_words), 32'd0);
        repeat (c_timeout - 1) step();
        chk("to_load16_disable", 32'(uart_disable), 32'd0);
        step();
        chk("to_fin_pc_reset", 32'(pc_reset), 32'd1);
        chk("to_fin_load_error", 32'(load_error), 32'd1);
        step();
        chk("to_idle_load_error", 32'(load_error), 32'd1);
        chk("to_idle_hazard", 32'(hazard_control), 32'(HAZD_CTL_NORMAL));

        // New session clears the error; done with a write counts and ends.
        uart_start = 1'b1;
        step();
        uart_start = 1'b0;
        chk("restart_load_error", 32'(load_error), 32'd0);
        repeat (c_drain) step();
        uart_write_enable = 1'b1;
        uart_addr = 15'h0005;
        uart_done = 1'b1;
        step();
        uart_write_enable = 1'b0;
        uart_done = 1'b0;
        chk("donew_imem", 32'(imem_words), 32'd1);
        chk("donew_pc_reset", 32'(pc_reset), 32'd1);
        step();

        // ---------------- done on the timeout cycle ----------------
        enter_load();
        repeat (c_timeout - 1) step();
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
        chk("doneto_pc_reset", 32'(pc_reset), 32'd1);
        chk("doneto_load_error", 32'(load_error), 32'd0);
        step();

        // ---------------- start held across a whole session ----------------
        uart_start = 1'b1;
        step();
        repeat (c_drain) step();
        chk("held_load_disable", 32'(uart_disable), 32'd0);
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
        step();
        repeat (3) step();
        chk("held_idle_loading", 32'(loading), 32'd0);
        chk("held_idle_hazard", 32'(hazard_control), 32'(HAZD_CTL_NORMAL));
        uart_start = 1'b0;
        step();

        // ---------------- start pulses in DRAIN and LOAD ignored ----------------
        uart_start = 1'b1;
        step();
        uart_start = 1'b0;
        step();
        uart_start = 1'b1;
        step();
        uart_start = 1'b0;
        step();
        step();
        chk("drainpulse_disable", 32'(uart_disable), 32'd0);
        uart_write_enable = 1'b1;
        uart_addr = 15'h0000;
        uart_start = 1'b1;
        step();
        uart_write_enable = 1'b0;
        uart_start = 1'b0;
        step();
        chk("loadpulse_imem", 32'(imem_words), 32'd1);
        chk("loadpulse_disable", 32'(uart_disable), 32'd0);
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
        step();
        step();
        chk("pulse_idle_loading", 32'(loading), 32'd0);

        // ---------------- asynchronous reset mid-LOAD ----------------
        enter_load();
        uart_write_enable = 1'b1;
        uart_addr = 15'h0000;
        step();
        chk("arst_pre_imem", 32'(imem_words), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_disable", 32'(uart_disable), 32'd1);
        chk("arst_uart_rst_n", 32'(uart_rst_n), 32'd0);
        chk("arst_hazard", 32'(hazard_control), 32'(HAZD_CTL_NORMAL));
        chk("arst_loading", 32'(loading), 32'd0);
        chk("arst_imem", 32'(imem_words), 32'd0);
        uart_write_enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("arst_after_loading", 32'(loading), 32'd0);

        // ---------------- counter saturation ----------------
        enter_load();
        uart_write_enable = 1'b1;
        uart_addr = 15'h0003;
        repeat (20) step();
        uart_write_enable = 1'b0;
        chk("sat_imem", 32'(imem_words), 32'd15);
        chk("sat_dmem", 32'(dmem_words), 32'd0);
        chk("sat_still_load", 32'(uart_disable), 32'd0);
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
        step();
        chk("sat_hold_idle", 32'(imem_words), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_uart_load_sequencer
`default_nettype wire
